// File: rtl/vending_machine_multi_if.sv
// Coin-acceptor / dispenser / change-hopper signal bundle for vending_machine_multi.
// The master side is the front end and hopper; the vending FSM sits on the slave side.
interface vending_machine_multi_if #(
   parameter int CREDIT_W = 4
);
   logic                rupee_one;
   logic                rupee_two;
   logic                rupee_five;
   logic                cancel;
   logic                change_ready;
   logic                dispense;
   logic                change_valid;
   logic [CREDIT_W-1:0] change_amount;
   logic                coin_reject;
   logic [CREDIT_W-1:0] credit;
   logic [2:0]          state;

   modport master (
      output rupee_one, rupee_two, rupee_five, cancel, change_ready,
      input  dispense, change_valid, change_amount, coin_reject, credit, state
   );

   modport slave (
      input  rupee_one, rupee_two, rupee_five, cancel, change_ready,
      output dispense, change_valid, change_amount, coin_reject, credit, state
   );
endinterface

// File: rtl/vending_machine_multi.sv
// Multi-coin vending FSM: all outputs are registered, and dispense follows the qualifying coin edge by one cycle.
// Change/refund is held on change_valid/change_amount until change_ready is seen at a clock edge.
module vending_machine_multi #(
   parameter int PRICE      = 5,
   parameter int MAX_CREDIT = 15,
   parameter int CREDIT_W   = 4
)(
   input  logic                   clk,
   input  logic                   reset_n,
   vending_machine_multi_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'b000,
      S_COLLECT  = 3'b001,
      S_DISPENSE = 3'b010,
      S_CHANGE   = 3'b011,
      S_REFUND   = 3'b100
   } state_t;

   localparam logic [CREDIT_W:0] LP_PRICE = (CREDIT_W+1)'(PRICE);
   localparam logic [CREDIT_W:0] LP_MAX   = (CREDIT_W+1)'(MAX_CREDIT);

   state_t              r_state;
   state_t              w_next_state;
   logic [CREDIT_W-1:0] r_credit;
   logic [CREDIT_W-1:0] w_next_credit;
   logic [CREDIT_W-1:0] r_change_amount;
   logic [CREDIT_W-1:0] w_next_amount;
   logic                r_dispense;
   logic                w_next_dispense;
   logic                r_change_valid;
   logic                w_next_valid;
   logic                r_coin_reject;
   logic                w_next_reject;

   logic [1:0]          w_coin_cnt;
   logic                w_coin_any;
   logic                w_coin_ok;
   logic [CREDIT_W:0]   w_coin_val;
   logic [CREDIT_W:0]   w_sum;
   logic [CREDIT_W:0]   w_remain;

   // One extra bit on the sum so the overflow check sees values above MAX_CREDIT.
   assign w_coin_cnt = {1'b0, bus.rupee_one} + {1'b0, bus.rupee_two} + {1'b0, bus.rupee_five};
   assign w_coin_any = bus.rupee_one | bus.rupee_two | bus.rupee_five;
   assign w_coin_val = bus.rupee_five ? (CREDIT_W+1)'(5) :
                       bus.rupee_two  ? (CREDIT_W+1)'(2) : (CREDIT_W+1)'(1);
   assign w_sum      = {1'b0, r_credit} + w_coin_val;
   assign w_coin_ok  = (w_coin_cnt == 2'd1) && (w_sum <= LP_MAX);
   assign w_remain   = {1'b0, r_credit} - LP_PRICE;

   always_comb begin
      w_next_state    = r_state;
      w_next_credit   = r_credit;
      w_next_dispense = 1'b0;
      w_next_valid    = r_change_valid;
      w_next_amount   = r_change_amount;
      w_next_reject   = w_coin_any;

      case (r_state)
         S_IDLE, S_COLLECT: begin
            w_next_valid  = 1'b0;
            w_next_amount = '0;
            // cancel only counts once credit exists; it then wins over any coin
            if (r_state == S_COLLECT && bus.cancel) begin
               w_next_state  = S_REFUND;
               w_next_valid  = 1'b1;
               w_next_amount = r_credit;
            end else if (w_coin_ok) begin
               w_next_reject = 1'b0;
               w_next_credit = w_sum[CREDIT_W-1:0];
               if (w_sum >= LP_PRICE) begin
                  w_next_state    = S_DISPENSE;
                  w_next_dispense = 1'b1;
               end else begin
                  w_next_state = S_COLLECT;
               end
            end
         end
         S_DISPENSE: begin
            if (w_remain != '0) begin
               w_next_state  = S_CHANGE;
               w_next_credit = w_remain[CREDIT_W-1:0];
               w_next_valid  = 1'b1;
               w_next_amount = w_remain[CREDIT_W-1:0];
            end else begin
               w_next_state  = S_IDLE;
               w_next_credit = '0;
            end
         end
         S_CHANGE, S_REFUND: begin
            if (r_change_valid && bus.change_ready) begin
               w_next_state  = S_IDLE;
               w_next_credit = '0;
               w_next_valid  = 1'b0;
               w_next_amount = '0;
            end
         end
         default: begin
            w_next_state  = S_IDLE;
            w_next_credit = '0;
            w_next_valid  = 1'b0;
            w_next_amount = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state         <= S_IDLE;
         r_credit        <= '0;
         r_dispense      <= 1'b0;
         r_change_valid  <= 1'b0;
         r_change_amount <= '0;
         r_coin_reject   <= 1'b0;
      end else begin
         r_state         <= w_next_state;
         r_credit        <= w_next_credit;
         r_dispense      <= w_next_dispense;
         r_change_valid  <= w_next_valid;
         r_change_amount <= w_next_amount;
         r_coin_reject   <= w_next_reject;
      end
   end

   assign bus.state         = r_state;
   assign bus.credit        = r_credit;
   assign bus.dispense      = r_dispense;
   assign bus.change_valid  = r_change_valid;
   assign bus.change_amount = r_change_amount;
   assign bus.coin_reject   = r_coin_reject;

endmodule

// File: tb/tb_vending_machine_multi.sv
// Directed bench for vending_machine_multi: a PRICE=5 instance driven from a vector table
// and a PRICE=7/MAX_CREDIT=8 instance for the overflow-reject case.
module tb_vending_machine_multi;

   logic clk;
   logic reset_n;

   vending_machine_multi_if #(.CREDIT_W(4)) ifa ();
   vending_machine_multi_if #(.CREDIT_W(4)) ifb ();

   vending_machine_multi #(.PRICE(5), .MAX_CREDIT(15), .CREDIT_W(4)) dut_a (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (ifa)
   );

   vending_machine_multi #(.PRICE(7), .MAX_CREDIT(8), .CREDIT_W(4)) dut_b (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (ifb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // inputs {one,two,five,cancel,ready}; expected {state,credit,dispense,valid,amount,reject}
   typedef struct {
      logic [4:0]  in;
      logic [2:0]  st;
      logic [3:0]  cr;
      logic        disp;
      logic        cv;
      logic [3:0]  amt;
      logic        rej;
   } vec_t;

   vec_t vecs[$];
   int   n_cmp;
   int   n_bad;

   task automatic add(input logic [4:0] in, input logic [2:0] st, input int cr,
                      input logic disp, input logic cv, input int amt, input logic rej);
      vec_t v;
      v.in = in; v.st = st; v.cr = 4'(cr); v.disp = disp;
      v.cv = cv; v.amt = 4'(amt); v.rej = rej;
      vecs.push_back(v);
   endtask

   task automatic drive_a(input logic [4:0] in);
      {ifa.rupee_one, ifa.rupee_two, ifa.rupee_five, ifa.cancel, ifa.change_ready} = in;
   endtask

   task automatic drive_b(input logic [4:0] in);
      {ifb.rupee_one, ifb.rupee_two, ifb.rupee_five, ifb.cancel, ifb.change_ready} = in;
   endtask

   task automatic cmp(input string nm, input logic [13:0] act, input logic [13:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got st=%0d cr=%0d disp=%0b cv=%0b amt=%0d rej=%0b, want st=%0d cr=%0d disp=%0b cv=%0b amt=%0d rej=%0b",
                  nm, act[13:11], act[10:7], act[6], act[5], act[4:1], act[0],
                  exp[13:11], exp[10:7], exp[6], exp[5], exp[4:1], exp[0]);
      end
   endtask

   function automatic logic [13:0] obs_a();
      return {ifa.state, ifa.credit, ifa.dispense, ifa.change_valid, ifa.change_amount, ifa.coin_reject};
   endfunction

   function automatic logic [13:0] obs_b();
      return {ifb.state, ifb.credit, ifb.dispense, ifb.change_valid, ifb.change_amount, ifb.coin_reject};
   endfunction

   function automatic logic [13:0] pk(input logic [2:0] st, input int cr, input logic d,
                                      input logic cv, input int amt, input logic rej);
      return {st, 4'(cr), d, cv, 4'(amt), rej};
   endfunction

   task automatic step_a(input string nm, input logic [4:0] in, input logic [13:0] exp);
      drive_a(in);
      @(posedge clk); #1;
      cmp(nm, obs_a(), exp);
   endtask

   task automatic step_b(input string nm, input logic [4:0] in, input logic [13:0] exp);
      drive_b(in);
      @(posedge clk); #1;
      cmp(nm, obs_b(), exp);
   endtask

   localparam logic [4:0] NONE = 5'b00000;
   localparam logic [4:0] ONE  = 5'b10000;
   localparam logic [4:0] TWO  = 5'b01000;
   localparam logic [4:0] FIVE = 5'b00100;
   localparam logic [4:0] CAN  = 5'b00010;
   localparam logic [4:0] RDY  = 5'b00001;

   initial begin
      n_cmp = 0;
      n_bad = 0;
      reset_n = 1'b0;
      drive_a(NONE);
      drive_b(NONE);

      // five 1-rupee coins, dispense, no change
      add(ONE, 3'd1, 1, 0, 0, 0, 0);
      add(ONE, 3'd1, 2, 0, 0, 0, 0);
      add(ONE, 3'd1, 3, 0, 0, 0, 0);
      add(ONE, 3'd1, 4, 0, 0, 0, 0);
      add(ONE, 3'd2, 5, 1, 0, 0, 0);
      add(NONE, 3'd0, 0, 0, 0, 0, 0);
      // three 2-rupee coins, change of 1 held while ready is low
      add(TWO, 3'd1, 2, 0, 0, 0, 0);
      add(TWO, 3'd1, 4, 0, 0, 0, 0);
      add(TWO, 3'd2, 6, 1, 0, 0, 0);
      add(NONE, 3'd3, 1, 0, 1, 1, 0);
      add(NONE, 3'd3, 1, 0, 1, 1, 0);
      add(NONE, 3'd3, 1, 0, 1, 1, 0);
      add(ONE, 3'd3, 1, 0, 1, 1, 1);
      add(NONE, 3'd3, 1, 0, 1, 1, 0);
      add(RDY, 3'd0, 0, 0, 0, 0, 0);
      // cancel after one rupee refunds it
      add(ONE, 3'd1, 1, 0, 0, 0, 0);
      add(CAN, 3'd4, 1, 0, 1, 1, 0);
      add(NONE, 3'd4, 1, 0, 1, 1, 0);
      add(RDY, 3'd0, 0, 0, 0, 0, 0);
      // multi-coin rejects, and cancel beating a coin
      add(ONE | TWO, 3'd0, 0, 0, 0, 0, 1);
      add(NONE, 3'd0, 0, 0, 0, 0, 0);
      add(ONE, 3'd1, 1, 0, 0, 0, 0);
      add(ONE | TWO | FIVE, 3'd1, 1, 0, 0, 0, 1);
      add(CAN | TWO, 3'd4, 1, 0, 1, 1, 1);
      add(RDY, 3'd0, 0, 0, 0, 0, 0);
      // ready and cancel in IDLE do nothing; cancel in DISPENSE ignored
      add(RDY, 3'd0, 0, 0, 0, 0, 0);
      add(FIVE | CAN, 3'd2, 5, 1, 0, 0, 0);
      add(CAN, 3'd0, 0, 0, 0, 0, 0);
      // coin during DISPENSE rejected, change of 4
      add(TWO, 3'd1, 2, 0, 0, 0, 0);
      add(TWO, 3'd1, 4, 0, 0, 0, 0);
      add(FIVE, 3'd2, 9, 1, 0, 0, 0);
      add(ONE | RDY, 3'd3, 4, 0, 1, 4, 1);
      add(RDY, 3'd0, 0, 0, 0, 0, 0);

      #12;
      cmp("reset_a", obs_a(), pk(3'd0, 0, 0, 0, 0, 0));
      cmp("reset_b", obs_b(), pk(3'd0, 0, 0, 0, 0, 0));
      @(posedge clk); #1;
      reset_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         step_a($sformatf("vec%0d", i), vecs[i].in,
                {vecs[i].st, vecs[i].cr, vecs[i].disp, vecs[i].cv, vecs[i].amt, vecs[i].rej});
      end
      drive_a(NONE);

      // PRICE=7, MAX_CREDIT=8: overflow reject, then exact fill to the ceiling
      step_b("b_one",   ONE,  pk(3'd1, 1, 0, 0, 0, 0));
      step_b("b_five",  FIVE, pk(3'd1, 6, 0, 0, 0, 0));
      step_b("b_ovf",   FIVE, pk(3'd1, 6, 0, 0, 0, 1));
      step_b("b_idle6", NONE, pk(3'd1, 6, 0, 0, 0, 0));
      step_b("b_two",   TWO,  pk(3'd2, 8, 1, 0, 0, 0));
      step_b("b_chg",   NONE, pk(3'd3, 1, 0, 1, 1, 0));
      step_b("b_rdy",   RDY,  pk(3'd0, 0, 0, 0, 0, 0));
      drive_b(NONE);

      // asynchronous reset in the middle of CHANGE
      step_a("r_two1", TWO,  pk(3'd1, 2, 0, 0, 0, 0));
      step_a("r_two2", TWO,  pk(3'd1, 4, 0, 0, 0, 0));
      step_a("r_two3", TWO,  pk(3'd2, 6, 1, 0, 0, 0));
      step_a("r_chg",  NONE, pk(3'd3, 1, 0, 1, 1, 0));
      #2;
      reset_n = 1'b0;
      #1;
      cmp("r_async", obs_a(), pk(3'd0, 0, 0, 0, 0, 0));
      @(posedge clk); #1;
      cmp("r_held", obs_a(), pk(3'd0, 0, 0, 0, 0, 0));
      reset_n = 1'b1;
      step_a("r_post1", ONE,  pk(3'd1, 1, 0, 0, 0, 0));
      step_a("r_post2", FIVE, pk(3'd2, 6, 1, 0, 0, 0));
      step_a("r_post3", NONE, pk(3'd3, 1, 0, 1, 1, 0));
      step_a("r_post4", RDY,  pk(3'd0, 0, 0, 0, 0, 0));
      drive_a(NONE);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
